ahb_slave_resp: RTL and testbench

- AHB-Lite slave responder: the bus-side counterpart of the master-side testbench interface. Accepts address/data-phase transfers from any AHB master.
- Presents each transfer as a single request on a simple valid/ready user port, and returns HRDATA/HREADYOUT/HRESP.
- Sits between the AHB interconnect and a memory or register model.
- Generates protocol-correct two-cycle ERROR responses for user errors, illegal transfers and timeouts.

---
 rtl/ahb_pkg.sv | 55 +++++
 rtl/ahb_slave_resp_strb_gen.sv | 17 +
 rtl/ahb_slave_resp.sv | 167 ++++++++++++++++
 tb/tb_ahb_slave_resp.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers, used by the slave responder and the master-side bench.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Byte-lane enables for a transfer; lane_mask folds the address onto the bus width.
  function automatic logic [7:0] size_to_strb(input logic [2:0] size,
                                              input logic [2:0] addr_lsb,
                                              input logic [2:0] lane_mask);
    logic [7:0] lanes;
    case (size)
      3'd0:    lanes = 8'h01;
      3'd1:    lanes = 8'h03;
      3'd2:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    return lanes << (addr_lsb & lane_mask);
  endfunction

endpackage

// File: rtl/ahb_slave_resp_strb_gen.sv
// Combinational write-strobe generation from transfer size and low address bits.
module ahb_strb_gen
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]              i_size,
  input  logic [2:0]              i_addr_lsb,
  output logic [DATA_WIDTH/8-1:0] o_strb
);

  localparam int         NBYTES    = DATA_WIDTH / 8;
  localparam logic [2:0] LANE_MASK = 3'(NBYTES - 1);

  assign o_strb = NBYTES'(size_to_strb(i_size, i_addr_lsb, LANE_MASK));

endmodule

// File: rtl/ahb_slave_resp.sv
// AHB-Lite slave responder: turns each bus transfer into one valid/ready user request
// and builds OKAY or two-cycle ERROR responses (user error, illegal transfer, timeout).
module ahb_slave_resp
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = `AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH = `AHB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    hsel,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
`ifdef AHB_PROT
  input  logic [3:0]              hprot,
`endif
`ifdef AHB_WSTRB
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
`endif
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    usr_valid,
  output logic [ADDR_WIDTH-1:0]   usr_addr,
  output logic                    usr_write,
  output logic [2:0]              usr_size,
  output logic [2:0]              usr_burst,
`ifdef AHB_PROT
  output logic [3:0]              usr_prot,
`endif
  output logic [DATA_WIDTH/8-1:0] usr_strb,
  output logic [DATA_WIDTH-1:0]   usr_wdata,
  input  logic                    usr_ready,
  input  logic [DATA_WIDTH-1:0]   usr_rdata,
  input  logic                    usr_error
);

  localparam int              NBYTES   = DATA_WIDTH / 8;
  localparam logic [2:0]      MAX_SIZE = 3'($clog2(NBYTES));
  localparam int              TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  slave_state_e          r_state;
  logic [TO_W-1:0]       r_to_cnt;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [ADDR_WIDTH-1:0] w_align_mask;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_in_access;
  logic                  w_done;
  logic                  w_user_err;
  logic                  w_expire;
  logic                  w_take;
  logic                  w_rd_capture;

  assign w_accept     = hsel & hready & htrans[1];
  assign w_align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign w_legal      = (hsize <= MAX_SIZE) && ((haddr & w_align_mask) == '0);

  assign w_in_access  = (r_state == ST_ACCESS);
  assign w_done       = w_in_access & usr_ready & ~usr_error;
  assign w_user_err   = w_in_access & usr_ready & usr_error;
  assign w_expire     = w_in_access & ~usr_ready & (TIMEOUT != 0) & (r_to_cnt == TO_LAST);
  // A new address phase is only taken when this slave is not stalling the bus.
  assign w_take       = w_accept & ((r_state == ST_IDLE) | (r_state == ST_ERR2) | w_done);
  assign w_rd_capture = w_in_access & usr_ready & ~usr_write;

  assign usr_valid = w_in_access;
  assign usr_wdata = hwdata;
  assign hrdata    = w_rd_capture ? usr_rdata : r_hrdata;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_to_cnt  <= '0;
      r_hrdata  <= '0;
      usr_addr  <= '0;
      usr_write <= 1'b0;
      usr_size  <= '0;
      usr_burst <= '0;
`ifdef AHB_PROT
      usr_prot  <= '0;
`endif
    end else begin
      if (w_rd_capture) r_hrdata <= usr_rdata;
      if (w_take) begin
        r_state   <= w_legal ? ST_ACCESS : ST_ERR1;
        r_to_cnt  <= '0;
        usr_addr  <= haddr;
        usr_write <= hwrite;
        usr_size  <= hsize;
        usr_burst <= hburst;
`ifdef AHB_PROT
        usr_prot  <= hprot;
`endif
      end else begin
        unique case (r_state)
          ST_IDLE: r_to_cnt <= '0;
          ST_ACCESS: begin
            if (w_user_err || w_expire) begin
              r_state  <= ST_ERR2;
              r_to_cnt <= '0;
            end else if (w_done) begin
              r_state  <= ST_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TO_W'(1);
            end
          end
          ST_ERR1: r_state <= ST_ERR2;
          ST_ERR2: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef AHB_WSTRB
  // Bus strobes belong to the data phase, so they follow hwstrb just like usr_wdata.
  assign usr_strb = hwstrb;
`else
  logic [NBYTES-1:0] w_gen_strb;
  logic [NBYTES-1:0] r_usr_strb;

  ahb_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb_gen (
    .i_size     (hsize),
    .i_addr_lsb (haddr[2:0]),
    .o_strb     (w_gen_strb)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_usr_strb <= '0;
    else if (w_take) r_usr_strb <= w_gen_strb;
  end

  assign usr_strb = r_usr_strb;
`endif

  // NOTE: outputs get a default before the case so no branch can infer a latch.
  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (r_state)
      ST_ACCESS: begin
        hreadyout = usr_ready & ~usr_error;
        hresp     = w_user_err | w_expire;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hreadyout = 1'b1;
        hresp     = HRESP_ERROR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_resp.sv
// Directed bench for ahb_slave_resp: a transaction-level response model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_ahb_slave_resp;
  import ahb_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        usr_valid;
  logic [31:0] usr_addr;
  logic        usr_write;
  logic [2:0]  usr_size;
  logic [2:0]  usr_burst;
  logic [3:0]  usr_strb;
  logic [31:0] usr_wdata;
  logic        usr_ready;
  logic [31:0] usr_rdata;
  logic        usr_error;

  int n_checks = 0;
  int n_errors = 0;

  // Single slave on the bus: HREADY is this slave's own HREADYOUT.
  assign hready = hreadyout;

  always #5 clk = ~clk;

  ahb_slave_resp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .usr_valid (usr_valid),
    .usr_addr  (usr_addr),
    .usr_write (usr_write),
    .usr_size  (usr_size),
    .usr_burst (usr_burst),
    .usr_strb  (usr_strb),
    .usr_wdata (usr_wdata),
    .usr_ready (usr_ready),
    .usr_rdata (usr_rdata),
    .usr_error (usr_error)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Byte lanes touched by a transfer: one enable per byte starting at addr mod 4.
  function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [31:0] addr);
    logic [7:0] lanes = 8'h00;
    for (int b = 0; b < (1 << size); b++) lanes[(addr % 4) + b] = 1'b1;
    return lanes[3:0];
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  strb;
  } req_t;

  // Model: an outstanding user request, the stall cycles it has seen, and how many
  // ERROR response cycles the bus is still owed.
  initial begin : model
    bit          busy;
    req_t        req;
    int          waited;
    int          err_left;
    logic [31:0] last_rd;
    bit          e_ready, e_resp, e_valid;
    logic [31:0] e_rdata;
    busy = 0; waited = 0; err_left = 0; last_rd = '0;
    req = '{32'h0, 1'b0, 3'h0, 3'h0, 4'h0};
    forever begin
      @(negedge clk);
      e_valid = 0;
      e_rdata = last_rd;
      if (!rstn) begin
        busy = 0; waited = 0; err_left = 0; last_rd = '0;
        e_ready = 1; e_resp = 0; e_rdata = '0;
      end else if (err_left == 2) begin
        e_ready = 0; e_resp = 1;
      end else if (err_left == 1) begin
        e_ready = 1; e_resp = 1;
      end else if (busy) begin
        e_valid = 1;
        if (usr_ready) begin
          e_ready = !usr_error;
          e_resp  = usr_error;
          if (!req.write) e_rdata = usr_rdata;
        end else if (TIMEOUT > 0 && waited == TIMEOUT - 1) begin
          e_ready = 0; e_resp = 1;
        end else begin
          e_ready = 0; e_resp = 0;
        end
      end else begin
        e_ready = 1; e_resp = 0;
      end

      check("model_hreadyout", hreadyout, e_ready);
      check("model_hresp", hresp, e_resp);
      check("model_usr_valid", usr_valid, e_valid);
      check("model_hrdata", hrdata, e_rdata);
      if (e_valid) begin
        check("model_usr_addr", usr_addr, req.addr);
        check("model_usr_write", usr_write, req.write);
        check("model_usr_size", usr_size, req.size);
        check("model_usr_burst", usr_burst, req.burst);
        check("model_usr_strb", usr_strb, req.strb);
        if (req.write) check("model_usr_wdata", usr_wdata, hwdata);
      end

      @(posedge clk);
      if (rstn) begin
        if (err_left > 0) err_left--;
        if (busy) begin
          if (usr_ready) begin
            if (!req.write) last_rd = usr_rdata;
            busy = 0;
            if (usr_error) err_left = 1;
          end else if (TIMEOUT > 0 && waited == TIMEOUT - 1) begin
            busy = 0;
            err_left = 1;
          end else begin
            waited++;
          end
        end
        if (hsel && e_ready && htrans[1]) begin
          if (hsize <= 3'd2 && (haddr % (32'd1 << hsize)) == 0) begin
            busy   = 1;
            waited = 0;
            req    = '{haddr, hwrite, hsize, hburst, strb_of(hsize, haddr)};
          end else begin
            err_left = 2;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    hsize = 3'd0; hburst = HBURST_SINGLE;
  endtask

  task automatic bus_addr(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [2:0] burst);
    hsel = 1'b1; htrans = trans; hwrite = wr; haddr = addr; hsize = size; hburst = burst;
  endtask

  task automatic user(input logic rdy, input logic err, input logic [31:0] rd);
    usr_ready = rdy; usr_error = err; usr_rdata = rd;
  endtask

  initial begin : stimulus
    rstn = 1'b0;
    bus_idle();
    user(1'b0, 1'b0, 32'h0);
    hwdata = '0;

    @(negedge clk);
    check("rst_hreadyout", hreadyout, 1'b1);
    check("rst_hresp", hresp, 1'b0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_usr_valid", usr_valid, 1'b0);
    check("rst_usr_addr", usr_addr, 32'h0);
    check("rst_usr_strb", usr_strb, 4'h0);
    next_cycle();
    rstn = 1'b1;
    next_cycle();

    // Single zero-wait word write.
    bus_addr(HTRANS_NONSEQ, 1'b1, 32'h10, 3'd2, HBURST_SINGLE);
    next_cycle();
    bus_idle(); hwdata = 32'hDEADBEEF; user(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("t1_usr_valid", usr_valid, 1'b1);
    check("t1_usr_addr", usr_addr, 32'h10);
    check("t1_usr_strb", usr_strb, 4'hF);
    check("t1_usr_wdata", usr_wdata, 32'hDEADBEEF);
    check("t1_hreadyout", hreadyout, 1'b1);
    check("t1_hresp", hresp, 1'b0);
    next_cycle();
    user(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t1_valid_drop", usr_valid, 1'b0);

    // Byte write at address 2.
    next_cycle();
    bus_addr(HTRANS_NONSEQ, 1'b1, 32'h2, 3'd0, HBURST_SINGLE);
    next_cycle();
    bus_idle(); hwdata = 32'h00AB0000; user(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("t1b_usr_strb", usr_strb, 4'h4);
    check("t1b_usr_size", usr_size, 3'd0);
    next_cycle();
    user(1'b0, 1'b0, 32'h0);

    // Read with three wait states.
    bus_addr(HTRANS_NONSEQ, 1'b0, 32'h20, 3'd2, HBURST_SINGLE);
    next_cycle();
    bus_idle();
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check("t2_wait_hreadyout", hreadyout, 1'b0);
      next_cycle();
    end
    user(1'b1, 1'b0, 32'h12345678);
    @(negedge clk);
    check("t2_hreadyout", hreadyout, 1'b1);
    check("t2_hrdata", hrdata, 32'h12345678);
    next_cycle();
    user(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t2_hrdata_hold", hrdata, 32'h12345678);

    // INCR4 write burst, back to back.
    next_cycle();
    bus_addr(HTRANS_NONSEQ, 1'b1, 32'h100, 3'd2, HBURST_INCR4);
    user(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i < 3) bus_addr(HTRANS_SEQ, 1'b1, 32'h104 + 32'(4 * i), 3'd2, HBURST_INCR4);
      else bus_idle();
      hwdata = 32'h1000 + 32'(i);
      @(negedge clk);
      check("t3_usr_valid", usr_valid, 1'b1);
      check("t3_usr_addr", usr_addr, 32'h100 + 32'(4 * i));
      check("t3_usr_burst", usr_burst, 3'd3);
      check("t3_hreadyout", hreadyout, 1'b1);
    end
    next_cycle();
    user(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("t3_valid_drop", usr_valid, 1'b0);

    // Misaligned halfword, then oversized transfer.
    next_cycle();
    bus_addr(HTRANS_NONSEQ, 1'b0, 32'h3, 3'd1, HBURST_SINGLE);
    next_cycle();
    bus_idle();
    @(negedge clk);
    check("t4_err1_hresp", hresp, 1'b1);
    check("t4_err1_hreadyout", hreadyout, 1'b0);
    check("t4_err1_usr_valid", usr_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("t4_err2_hresp", hresp, 1'b1);
    check("t4_err2_hreadyout", hreadyout, 1'b1);
    check("t4_err2_usr_valid", usr_valid, 1'b0);
    next_cycle();
    bus_addr(HTRANS_NONSEQ, 1'b0, 32'h8, 3'd3, HBURST_SINGLE);
    next_cycle();
    bus_idle();
    @(negedge clk);
    check("t4_size_err1_hresp", hresp, 1'b1);
    check("t4_size_err1_hreadyout", hreadyout, 1'b0);
    next_cycle();
    next_cycle();

    // User error on a write, then a read accepted during the second ERROR cycle.
    bus_addr(HTRANS_NONSEQ, 1'b1, 32'h40, 3'd2, HBURST_SINGLE);
    next_cycle();
    bus_idle(); hwdata = 32'h55AA55AA; user(1'b1, 1'b1, 32'h0);
    @(negedge clk);
    check("t5_err1_hresp", hresp, 1'b1);
    check("t5_err1_hreadyout", hreadyout, 1'b0);
    next_cycle();
    user(1'b0, 1'b0, 32'h0);
    bus_addr(HTRANS_NONSEQ, 1'b0, 32'h44, 3'd2, HBURST_SINGLE);
    @(negedge clk);
    check("t5_err2_hresp", hresp, 1'b1);
    check("t5_err2_hreadyout", hreadyout, 1'b1);
    next_cycle();
    bus_idle(); user(1'b1, 1'b0, 32'hCAFEF00D);
    @(negedge clk);
    check("t5_rd_usr_addr", usr_addr, 32'h44);
    check("t5_rd_hresp", hresp, 1'b0);
    check("t5_rd_hreadyout", hreadyout, 1'b1);
    check("t5_rd_hrdata", hrdata, 32'hCAFEF00D);
    next_cycle();
    user(1'b0, 1'b0, 32'h0);

    // Timeout with usr_ready stuck low.
    bus_addr(HTRANS_NONSEQ, 1'b0, 32'h80, 3'd2, HBURST_SINGLE);
    next_cycle();
    bus_idle();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 15) begin
        check("t6_c15_hresp", hresp, 1'b0);
        check("t6_c15_hreadyout", hreadyout, 1'b0);
      end
      if (c == 16) begin
        check("t6_c16_hresp", hresp, 1'b1);
        check("t6_c16_hreadyout", hreadyout, 1'b0);
        check("t6_c16_usr_valid", usr_valid, 1'b1);
      end
      next_cycle();
    end
    @(negedge clk);
    check("t6_err2_hresp", hresp, 1'b1);
    check("t6_err2_hreadyout", hreadyout, 1'b1);
    check("t6_err2_usr_valid", usr_valid, 1'b0);
    next_cycle();

    // Asynchronous reset in the fifth ACCESS cycle.
    bus_addr(HTRANS_NONSEQ, 1'b1, 32'h90, 3'd2, HBURST_SINGLE);
    next_cycle();
    bus_idle();
    for (int c = 1; c < 5; c++) next_cycle();
    check("t7_pre_usr_valid", usr_valid, 1'b1);
    check("t7_pre_usr_addr", usr_addr, 32'h90);
    rstn = 1'b0;
    #1;
    check("t7_rst_hreadyout", hreadyout, 1'b1);
    check("t7_rst_hresp", hresp, 1'b0);
    check("t7_rst_usr_valid", usr_valid, 1'b0);
    check("t7_rst_usr_addr", usr_addr, 32'h0);
    check("t7_rst_hrdata", hrdata, 32'h0);
    next_cycle();
    rstn = 1'b1;
    next_cycle();

    // Recovery: zero-wait read after reset.
    bus_addr(HTRANS_NONSEQ, 1'b0, 32'h24, 3'd2, HBURST_SINGLE);
    next_cycle();
    bus_idle(); user(1'b1, 1'b0, 32'h0BADF00D);
    @(negedge clk);
    check("t8_hrdata", hrdata, 32'h0BADF00D);
    check("t8_hreadyout", hreadyout, 1'b1);
    next_cycle();
    user(1'b0, 1'b0, 32'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
